pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_hazard_det.sv | 23 ++
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline control block.
package pipe_ctrl_pkg;

    // Control FSM states: normal issue, or waiting on a multi-cycle EX op.
    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    // Default number of MC_WAIT cycles before the wait is abandoned.
    localparam logic [15:0] TIMEOUT_DEF = 16'd1024;

    // Bubble contents: all-zero word, register x0.
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [4:0]  ZERO_REG  = 5'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
module hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic [4:0] rd_addr,
    input  logic       is_load,
    input  logic       reg_wen,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real dependency, on either side of the compare.
    always_comb begin
        rs1_hit  = (rs1_addr != ZERO_REG) && (rs1_addr == rd_addr);
        rs2_hit  = (rs2_addr != ZERO_REG) && (rs2_addr == rd_addr);
        load_use = is_load && reg_wen && (rd_addr != ZERO_REG) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: redirects on jumps, stalls on load-use and multi-cycle
// EX operations, counts stall/flush cycles and flags a stuck multi-cycle op.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEF,
    parameter int          CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_reg_wen_i,
    input  logic             ex_is_load_i,
    input  logic             ex_jump_en_i,
    input  logic [31:0]      ex_jump_addr_i,
    input  logic             ex_busy_req_i,
    input  logic             ex_busy_done_i,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             hold_id_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             timeout_o
);

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_cnt;
    logic        load_use;
    logic        timeout_fire;

    hazard_det u_hazard_det (
        .rs1_addr (id_rs1_addr_i),
        .rs2_addr (id_rs2_addr_i),
        .rd_addr  (ex_rd_addr_i),
        .is_load  (ex_is_load_i),
        .reg_wen  (ex_reg_wen_i),
        .load_use (load_use)
    );

    // Next state and all control outputs; everything is quiet while in reset.
    always_comb begin
        next_state    = state;
        jump_en_o     = 1'b0;
        jump_addr_o   = ZERO_WORD;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        timeout_fire  = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (ex_jump_en_i) begin
                        // A taken jump wins over a busy request, which is squashed.
                        jump_en_o     = 1'b1;
                        jump_addr_o   = ex_jump_addr_i;
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (ex_busy_req_i) begin
                        hold_pc_o    = 1'b1;
                        hold_if_id_o = 1'b1;
                        hold_id_ex_o = 1'b1;
                        next_state   = MC_WAIT;
                    end else if (load_use) begin
                        hold_pc_o     = 1'b1;
                        hold_if_id_o  = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (ex_busy_done_i) begin
                        next_state = RUN;
                    end else if (wait_cnt == TIMEOUT - 16'd1) begin
                        // Give up on the stuck op and let the pipe move again.
                        timeout_fire = 1'b1;
                        next_state   = RUN;
                    end else begin
                        hold_pc_o    = 1'b1;
                        hold_if_id_o = 1'b1;
                        hold_id_ex_o = 1'b1;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Wait counter: held at zero in RUN so each MC_WAIT visit starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == RUN) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_o <= 1'b0;
        end else if (timeout_fire) begin
            timeout_o <= 1'b1;
        end
    end

    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (hold_pc_o) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (flush_id_ex_o) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: per-cycle reference model plus directed scenarios.
module tb_pipe_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        wen = 1'b0, is_load = 1'b0, jump = 1'b0, busy = 1'b0, done = 1'b0;
    logic [31:0] jaddr = '0;

    logic        jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, timeout;
    logic [31:0] jump_addr, stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.TIMEOUT(16'(TO)), .CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1_addr_i  (rs1),
        .id_rs2_addr_i  (rs2),
        .ex_rd_addr_i   (rd),
        .ex_reg_wen_i   (wen),
        .ex_is_load_i   (is_load),
        .ex_jump_en_i   (jump),
        .ex_jump_addr_i (jaddr),
        .ex_busy_req_i  (busy),
        .ex_busy_done_i (done),
        .jump_en_o      (jump_en),
        .jump_addr_o    (jump_addr),
        .hold_pc_o      (hold_pc),
        .hold_if_id_o   (hold_if_id),
        .hold_id_ex_o   (hold_id_ex),
        .flush_if_id_o  (flush_if_id),
        .flush_id_ex_o  (flush_id_ex),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: "waiting" is true while a multi-cycle op is outstanding,
    // "waited" counts completed wait cycles of the current op.
    bit          waiting = 1'b0;
    int          waited  = 0;
    bit          m_to    = 1'b0;
    logic [31:0] m_stall = '0, m_flush = '0;

    always @(negedge clk) begin
        bit e_jen, e_hpc, e_hif, e_hide, e_fif, e_fide, luse;
        logic [31:0] e_jaddr;
        e_jen = 0; e_hpc = 0; e_hif = 0; e_hide = 0; e_fif = 0; e_fide = 0;
        e_jaddr = 32'h0;
        if (!rst_n) begin
            waiting = 1'b0; waited = 0; m_to = 1'b0; m_stall = '0; m_flush = '0;
        end else begin
            luse = is_load && wen && rd != 0 &&
                   ((rs1 != 0 && rs1 == rd) || (rs2 != 0 && rs2 == rd));
            if (!waiting) begin
                if (jump) begin
                    e_jen = 1; e_jaddr = jaddr; e_fif = 1; e_fide = 1;
                end else if (busy) begin
                    e_hpc = 1; e_hif = 1; e_hide = 1;
                end else if (luse) begin
                    e_hpc = 1; e_hif = 1; e_fide = 1;
                end
            end else if (!done && waited < TO - 1) begin
                e_hpc = 1; e_hif = 1; e_hide = 1;
            end
        end
        chk("jump_en", 32'(jump_en), 32'(e_jen));
        chk("jump_addr", jump_addr, e_jaddr);
        chk("hold_pc", 32'(hold_pc), 32'(e_hpc));
        chk("hold_if_id", 32'(hold_if_id), 32'(e_hif));
        chk("hold_id_ex", 32'(hold_id_ex), 32'(e_hide));
        chk("flush_if_id", 32'(flush_if_id), 32'(e_fif));
        chk("flush_id_ex", 32'(flush_id_ex), 32'(e_fide));
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        chk("timeout", 32'(timeout), 32'(m_to));
        // Advance the model to what the coming rising edge should produce.
        if (rst_n) begin
            m_stall += 32'(e_hpc);
            m_flush += 32'(e_fide);
            if (!waiting) begin
                if (busy && !jump) begin waiting = 1'b1; waited = 0; end
            end else if (done) begin
                waiting = 1'b0;
            end else if (waited == TO - 1) begin
                waiting = 1'b0; m_to = 1'b1;
            end else begin
                waited++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; wen = 0; is_load = 0;
        jump = 0; jaddr = 0; busy = 0; done = 0;
    endtask

    task automatic do_reset();
        step();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    int holds;

    initial begin
        idle();
        // Reset state.
        at_neg();
        chk("rst_hold_pc", 32'(hold_pc), 32'd0);
        chk("rst_jump_addr", jump_addr, 32'h0);
        do_reset();

        // Load x5 in EX, ID reads x5: one stall cycle.
        is_load = 1; wen = 1; rd = 5; rs1 = 5;
        at_neg();
        chk("lu_hold_pc", 32'(hold_pc), 32'd1);
        chk("lu_flush_id_ex", 32'(flush_id_ex), 32'd1);
        step();
        idle();
        at_neg();
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        chk("lu_flush_cnt", flush_cnt, 32'd1);

        // Match on rs2, and a non-writing load that must not stall.
        step();
        is_load = 1; wen = 1; rd = 9; rs2 = 9; rs1 = 3;
        step();
        wen = 0;
        at_neg();
        chk("nowen_hold_pc", 32'(hold_pc), 32'd0);
        step();
        idle();

        // Load to x0 read as x0: no stall.
        is_load = 1; wen = 1; rd = 0; rs1 = 0;
        at_neg();
        chk("x0_hold_pc", 32'(hold_pc), 32'd0);
        step();
        idle();

        // Jump with a simultaneous load-use.
        do_reset();
        jump = 1; jaddr = 32'h0000_0100; is_load = 1; wen = 1; rd = 7; rs1 = 7;
        at_neg();
        chk("jmp_en", 32'(jump_en), 32'd1);
        chk("jmp_addr", jump_addr, 32'h0000_0100);
        chk("jmp_flush_if_id", 32'(flush_if_id), 32'd1);
        chk("jmp_hold_pc", 32'(hold_pc), 32'd0);
        step();
        // Jump together with busy_req: stays in RUN.
        idle();
        jump = 1; jaddr = 32'h0000_0200; busy = 1;
        step();
        idle();
        at_neg();
        chk("jmpbusy_hold_pc", 32'(hold_pc), 32'd0);
        chk("jmp_flush_cnt", flush_cnt, 32'd2);
        chk("jmp_stall_cnt", stall_cnt, 32'd0);

        // Multi-cycle op, done after 5 wait cycles; jump/load-use ignored while waiting.
        do_reset();
        done = 1;            // done in RUN is ignored
        step();
        holds = 0;
        busy = 1; done = 0;
        at_neg();
        holds += int'(hold_pc);
        for (int i = 0; i < 6; i++) begin
            step();
            idle();
            if (i == 1) begin jump = 1; jaddr = 32'hDEAD_BEEF; end
            if (i == 2) begin is_load = 1; wen = 1; rd = 4; rs1 = 4; end
            if (i == 5) done = 1;
            at_neg();
            holds += int'(hold_pc);
            if (i == 1) chk("wait_jump_ignored", 32'(jump_en), 32'd0);
        end
        chk("mc_hold_cycles", 32'(holds), 32'd6);
        step();
        idle();
        at_neg();
        chk("mc_stall_cnt", stall_cnt, 32'd6);
        chk("mc_back_to_run", 32'(hold_pc), 32'd0);

        // Timeout with done never asserted.
        do_reset();
        busy = 1;
        step();
        idle();
        for (int i = 0; i < 8; i++) step();
        at_neg();
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_hold_pc", 32'(hold_pc), 32'd0);
        chk("to_stall_cnt", stall_cnt, 32'd8);
        step();
        at_neg();
        chk("to_sticky", 32'(timeout), 32'd1);

        // Asynchronous reset in the 3rd wait cycle.
        do_reset();
        busy = 1;
        step();
        idle();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_hold_pc", 32'(hold_pc), 32'd0);
        chk("arst_hold_id_ex", 32'(hold_id_ex), 32'd0);
        chk("arst_stall_cnt", stall_cnt, 32'd0);
        step();
        rst_n = 1'b1;
        at_neg();
        chk("arst_run_hold_pc", 32'(hold_pc), 32'd0);
        step();
        at_neg();
        chk("arst_run_stall", stall_cnt, 32'd0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
